npu_config_loader: RTL and testbench
====================================

Name: npu_config_loader

Overview:
- Upstream feeder of the NPU state machine's config path.
- Pops 16-bit command words from the config FIFO (first-word-fall-through) while the NPU is in its config state.
- Decodes commands into input/output count register writes (npu_state_data_in plus enable pulses) and burst writes into the PE weight memory.
- Flags malformed commands with a sticky error.

Parameters:
- WGT_ADDR_W, 10: weight memory address width; the address wraps modulo 2^WGT_ADDR_W.
- DATA_W, 16: config word width. Fixed at 16; other values are unsupported.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- npu_state_config  in  1  NPU state machine is in config state; loader may consume only while high
- npu_config_fifo_empty  in  1  config FIFO empty
- npu_config_fifo_data  in  16  FWFT head word, valid whenever ~empty
- npu_config_fifo_read_en  out  1  pop strobe (combinational)
- npu_state_data_in  out  16  count value to state machine (registered)
- npu_state_input_reg_enable  out  1  1-cycle pulse: load input count
- npu_state_output_reg_enable  out  1  1-cycle pulse: load output count
- npu_wgt_we  out  1  weight memory write enable (registered)
- npu_wgt_addr  out  WGT_ADDR_W  weight write address
- npu_wgt_data  out  16  weight write data
- npu_cfg_busy  out  1  high when the FSM is not in S_HDR (mid-command)
- npu_cfg_err  out  1  sticky error, cleared only by RST

Behaviour:
- Pop rule: npu_config_fifo_read_en = npu_state_config & ~npu_config_fifo_empty. At most one word per cycle. The word is consumed in the cycle read_en is high.
- Header word format: [15:12] opcode, [11:0] LEN.
- Opcodes:
  - 4'h0 NOP: no effect.
  - 4'h1 SET_IN: the next word is the input count.
  - 4'h2 SET_OUT: the next word is the output count.
  - 4'h3 LOAD_WGT: the next word is the base address (low WGT_ADDR_W bits used), followed by LEN weight words.
  - Any other opcode: set npu_cfg_err, treat the word as a NOP, stay in S_HDR.
- FSM states:
  - S_HDR: on pop, decode the opcode. SET_IN/SET_OUT go to S_ARG, latching which count is targeted. LOAD_WGT latches LEN into a 12-bit remaining counter and goes to S_BASE.
  - S_ARG: on pop, register data into npu_state_data_in and pulse the selected enable for exactly 1 cycle (the cycle after the pop). Return to S_HDR.
  - S_BASE: on pop, load the address counter. If remaining == 0, go to S_HDR and perform no writes. Otherwise go to S_BURST.
  - S_BURST: on each pop, the next cycle shows npu_wgt_we=1, addr=current, data=word. Then addr += 1 (wraps 2^WGT_ADDR_W-1 -> 0) and remaining -= 1. When the pop that makes remaining 0 occurs, go to S_HDR.
- Latency: one cycle from pop to the registered output (enable pulse or wgt_we).
- npu_state_data_in holds its last value between pulses.
- Stall: if the FIFO is empty or npu_state_config is low, there is no pop, the FSM holds its state and counters, and all pulses and npu_wgt_we are 0.
  - A command split across config sessions resumes where it left off. The state machine leaves config whenever the FIFO runs empty, so this is normal operation.
- Back-to-back: a header may be popped in the cycle directly after the last word of the previous command, giving a sustained 1 word/cycle.
- SET_IN and SET_OUT enables are never high in the same cycle.
- npu_cfg_busy = (state != S_HDR), registered with the state.
- npu_cfg_err: set on an undefined opcode and held until RST.
- Reset (including mid-burst): state S_HDR, counters 0, npu_state_data_in=0, both enables 0, npu_wgt_we=0, npu_wgt_addr=0, npu_wgt_data=0, npu_cfg_busy=0, npu_cfg_err=0. The partial command is discarded.

Test Plan:
- SET_IN:
  - FIFO {0x1000, 0x0005}, config=1 -> two pops.
  - npu_state_data_in=0x0005 with input_reg_enable high for one cycle, on the cycle after the second pop.
  - output_reg_enable stays 0.
- Weight burst with wrap:
  - FIFO {0x3003, 0x03FE, 0xAAAA, 0xBBBB, 0xCCCC}, WGT_ADDR_W=10.
  - Required writes: 0x3FE<-0xAAAA, 0x3FF<-0xBBBB, 0x000<-0xCCCC, on consecutive cycles.
  - busy falls the cycle after the last pop.
- Zero-length and NOP:
  - FIFO {0x3000, 0x0010, 0x0000, 0x2000, 0x0007}.
  - No wgt_we pulses.
  - output_reg_enable pulses once with data 0x0007.
- Stall/resume:
  - Burst LEN=2: deliver the header, base and one weight, then make the FIFO empty and config=0 for 5 cycles, then deliver the last weight with config=1.
  - No activity during the gap; second write lands at base+1; busy stays 1 throughout the gap.
- Bad opcode:
  - Header 0x7123, then {0x1000, 0x0009}.
  - err=1 and stays 1.
  - The following SET_IN still loads 0x0009 correctly.
- Reset mid-burst:
  - Assert RST after 1 of 4 weights.
  - All outputs 0, busy=0.
  - A fresh SET_OUT {0x2000, 0x0003} after RST decodes as a header, not as weight data.

Source files
------------

// File: rtl/npu_config_loader.sv
// Config-path feeder for the NPU: pops command words from a FWFT FIFO.
// Decodes them into count-register loads and weight-memory burst writes.
module npu_config_loader #(
  parameter int WGT_ADDR_W = 10,
  parameter int DATA_W     = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  npu_state_config,
  input  logic                  npu_config_fifo_empty,
  input  logic [DATA_W-1:0]     npu_config_fifo_data,
  output logic                  npu_config_fifo_read_en,
  output logic [DATA_W-1:0]     npu_state_data_in,
  output logic                  npu_state_input_reg_enable,
  output logic                  npu_state_output_reg_enable,
  output logic                  npu_wgt_we,
  output logic [WGT_ADDR_W-1:0] npu_wgt_addr,
  output logic [DATA_W-1:0]     npu_wgt_data,
  output logic                  npu_cfg_busy,
  output logic                  npu_cfg_err
);

  typedef enum logic [1:0] {S_HDR, S_ARG, S_BASE, S_BURST} state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_SET_IN = 4'h1, OP_SET_OUT = 4'h2, OP_LOAD_WGT = 4'h3;

  state_t                state;
  logic                  sel_out;
  logic [11:0]           remaining;
  logic [WGT_ADDR_W-1:0] addr_cnt;
  logic                  pop;
  logic [3:0]            opcode;

  assign pop = npu_state_config & ~npu_config_fifo_empty;
  assign npu_config_fifo_read_en = pop;
  assign opcode = npu_config_fifo_data[15:12];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state                       <= S_HDR;
      sel_out                     <= 1'b0;
      remaining                   <= '0;
      addr_cnt                    <= '0;
      npu_state_data_in           <= '0;
      npu_state_input_reg_enable  <= 1'b0;
      npu_state_output_reg_enable <= 1'b0;
      npu_wgt_we                  <= 1'b0;
      npu_wgt_addr                <= '0;
      npu_wgt_data                <= '0;
      npu_cfg_busy                <= 1'b0;
      npu_cfg_err                 <= 1'b0;
    end else begin
      // Pulses default low; stalls leave state and counters untouched.
      npu_state_input_reg_enable  <= 1'b0;
      npu_state_output_reg_enable <= 1'b0;
      npu_wgt_we                  <= 1'b0;
      if (pop) begin
        case (state)
          S_HDR: begin
            case (opcode)
              OP_NOP: ;
              OP_SET_IN, OP_SET_OUT: begin
                sel_out      <= (opcode == OP_SET_OUT);
                state        <= S_ARG;
                npu_cfg_busy <= 1'b1;
              end
              OP_LOAD_WGT: begin
                remaining    <= npu_config_fifo_data[11:0];
                state        <= S_BASE;
                npu_cfg_busy <= 1'b1;
              end
              default: npu_cfg_err <= 1'b1;
            endcase
          end
          S_ARG: begin
            npu_state_data_in           <= npu_config_fifo_data;
            npu_state_input_reg_enable  <= ~sel_out;
            npu_state_output_reg_enable <= sel_out;
            state                       <= S_HDR;
            npu_cfg_busy                <= 1'b0;
          end
          S_BASE: begin
            addr_cnt <= npu_config_fifo_data[WGT_ADDR_W-1:0];
            if (remaining == 12'd0) begin
              state        <= S_HDR;
              npu_cfg_busy <= 1'b0;
            end else begin
              state <= S_BURST;
            end
          end
          S_BURST: begin
            npu_wgt_we   <= 1'b1;
            npu_wgt_addr <= addr_cnt;
            npu_wgt_data <= npu_config_fifo_data;
            addr_cnt     <= addr_cnt + 1'b1;
            remaining    <= remaining - 12'd1;
            if (remaining == 12'd1) begin
              state        <= S_HDR;
              npu_cfg_busy <= 1'b0;
            end
          end
          default: state <= S_HDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npu_config_loader.sv
// Scoreboard bench for npu_config_loader: a queue-backed FWFT FIFO feeds commands,
// expected writes/pulses are queued up front and matched as the DUT emits them.
module tb_npu_config_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        cfg = 1'b0;
  logic        fempty = 1'b1;
  logic [15:0] fdata = '0;
  logic        ren;
  logic [15:0] data_in;
  logic        in_en, out_en, we;
  logic [9:0]  waddr;
  logic [15:0] wdata;
  logic        busy, err;

  int total = 0;
  int bad   = 0;
  logic [15:0] fq[$];
  logic [35:0] sb[$];

  always #5 CLK = ~CLK;

  npu_config_loader #(.WGT_ADDR_W(10), .DATA_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .npu_state_config(cfg),
    .npu_config_fifo_empty(fempty),
    .npu_config_fifo_data(fdata),
    .npu_config_fifo_read_en(ren),
    .npu_state_data_in(data_in),
    .npu_state_input_reg_enable(in_en),
    .npu_state_output_reg_enable(out_en),
    .npu_wgt_we(we),
    .npu_wgt_addr(waddr),
    .npu_wgt_data(wdata),
    .npu_cfg_busy(busy),
    .npu_cfg_err(err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [35:0] ev(input logic [3:0] kind, input logic [15:0] addr, input logic [15:0] data);
    return {kind, addr, data};
  endfunction

  task automatic refresh();
    fempty = (fq.size() == 0);
    fdata  = fempty ? 16'h0 : fq[0];
  endtask

  task automatic sb_match(input logic [35:0] obs);
    if (sb.size() == 0) chk("extra_event", obs, 0);
    else chk("sb_event", obs, sb.pop_front());
  endtask

  // FIFO model: pop the head after the edge that consumed it.
  always @(posedge CLK) begin : fifo_model
    bit p;
    p = ren;
    #1;
    if (p && fq.size() > 0) void'(fq.pop_front());
    refresh();
  end

  always @(negedge CLK) begin
    if (!RST) begin
      if (in_en && out_en) chk("both_enables", 1, 0);
      if (we)     sb_match(ev(4'd1, {6'b0, waddr}, wdata));
      if (in_en)  sb_match(ev(4'd2, 16'h0, data_in));
      if (out_en) sb_match(ev(4'd3, 16'h0, data_in));
    end
  end

  task automatic push(input logic [15:0] w);
    fq.push_back(w);
    refresh();
  endtask

  task automatic wait_empty();
    int n = 0;
    while (fq.size() != 0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (fq.size() != 0) chk("timeout", 1, 0);
  endtask

  task automatic drain(input string tag);
    repeat (2) @(negedge CLK);
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_outs", {data_in, in_en, out_en, we, waddr, wdata, busy, err}, 0);
    RST = 1'b0;
    cfg = 1'b1;
    @(negedge CLK);

    // SET_IN with latency check
    sb.push_back(ev(4'd2, 16'h0, 16'h0005));
    push(16'h1000); push(16'h0005);
    wait_empty();
    chk("setin_pulse", {in_en, out_en}, 2'b10);
    chk("setin_data", data_in, 16'h0005);
    @(negedge CLK);
    chk("setin_one_cycle", in_en, 0);
    chk("setin_hold", data_in, 16'h0005);
    drain("setin_drain");

    // burst wrapping past the top of the weight space
    sb.push_back(ev(4'd1, 16'h03FE, 16'hAAAA));
    sb.push_back(ev(4'd1, 16'h03FF, 16'hBBBB));
    sb.push_back(ev(4'd1, 16'h0000, 16'hCCCC));
    push(16'h3003); push(16'h03FE); push(16'hAAAA); push(16'hBBBB); push(16'hCCCC);
    @(negedge CLK);
    chk("burst_busy_mid", busy, 1);
    wait_empty();
    chk("burst_busy_fall", busy, 0);
    chk("burst_last_we", {we, waddr, wdata}, {1'b1, 10'h000, 16'hCCCC});
    drain("burst_drain");

    // zero-length burst, NOP, then SET_OUT
    sb.push_back(ev(4'd3, 16'h0, 16'h0007));
    push(16'h3000); push(16'h0010); push(16'h0000); push(16'h2000); push(16'h0007);
    wait_empty();
    drain("zero_nop_drain");

    // stall mid-burst across a config gap
    sb.push_back(ev(4'd1, 16'h0100, 16'h1111));
    sb.push_back(ev(4'd1, 16'h0101, 16'h2222));
    push(16'h3002); push(16'h0100); push(16'h1111);
    wait_empty();
    cfg = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("stall_busy", busy, 1);
    end
    push(16'h2222);
    repeat (3) @(negedge CLK);
    chk("stall_no_pop", {ren, 8'(fq.size())}, {1'b0, 8'd1});
    cfg = 1'b1;
    wait_empty();
    chk("stall_resume_busy", busy, 0);
    drain("stall_drain");

    // undefined opcode: sticky error, next command unaffected
    chk("err_clear_before", err, 0);
    sb.push_back(ev(4'd2, 16'h0, 16'h0009));
    push(16'h7123); push(16'h1000); push(16'h0009);
    wait_empty();
    drain("badop_drain");
    chk("err_set", err, 1);
    repeat (4) @(negedge CLK);
    chk("err_sticky", err, 1);
    chk("badop_data", data_in, 16'h0009);

    // reset in the middle of a 4-word burst
    sb.push_back(ev(4'd1, 16'h0050, 16'hD00D));
    push(16'h3004); push(16'h0050); push(16'hD00D);
    wait_empty();
    @(negedge CLK);
    chk("rst_pre_busy", busy, 1);
    drain("rst_pre_drain");
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("rst_mid_outs", {data_in, in_en, out_en, we, waddr, wdata, busy, err}, 0);
    RST = 1'b0;
    sb.push_back(ev(4'd3, 16'h0, 16'h0003));
    push(16'h2000); push(16'h0003);
    wait_empty();
    chk("rst_setout_pulse", {in_en, out_en, data_in}, {2'b01, 16'h0003});
    drain("rst_post_drain");
    chk("rst_post_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
